untransrf_b4r5g3: RTL and testbench
===================================

# untransrf_b4r5g3

Parallel-to-serial register file that accepts 20-bit words (5 rows × 4-bit nibbles) in one cycle and returns them one nibble per read, oldest word first. It is the transmit-side counterpart of the 4-bit-in / 20-bit-out transposing register file: three groups of storage, each filled with one wide write and drained by five narrow reads. It sits between the wide MAC result bus and a nibble-serial consumer. Everything runs in the single clock domain clk_w.

## Interface
- BITS, 4: nibble width (r_data width).
- ROWS, 5: nibbles per word; write word width is BITS*ROWS = 20.
- GROUPS, 3: storage groups (word slots).
- clk_w  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- w_en  in  1  write request; accepted when w_en && ~rf_full.
- w_data  in  20  word; w_data[19:16] is row 0 (first nibble out), w_data[3:0] is row 4 (last).
- r_en  in  1  read request; accepted when r_en && ~rf_empty.
- r_data  out  4  registered nibble.
- r_valid  out  1  high the cycle after an accepted read.
- r_last  out  1  high with r_valid when the nibble is row 4 of its group.
- rf_full  out  1  all GROUPS groups occupied.
- rf_empty  out  1  no group occupied.

## Operation
- State: w_group (0..2), r_group (0..2), r_addr (0..4), occupancy count (0..3), storage GROUPS×ROWS×BITS.
- Write accepted: store all five nibbles of w_data into group w_group; w_group increments, wraps 2→0.
- Read accepted: r_data ← storage[r_group][r_addr]; r_valid←1; r_last←(r_addr==4). r_addr increments. At r_addr==4 it returns to 0, r_group increments (wraps 2→0), and the group is freed.
- count: +1 on accepted write, −1 on accepted read with r_addr==4, unchanged if both happen in the same cycle.
- rf_full = (count==3); rf_empty = (count==0). Both are combinational decodes of registered count.
- Write when full: ignored, no state change, even if the same cycle frees a group (no bypass).
- Read when empty: ignored; r_valid=0, r_last=0, pointers unchanged.
- A partially drained group stays occupied; the writer cannot overwrite it until its fifth nibble is read.
- Reset (any time, including mid-group): pointers, count, storage cleared to 0; r_data=0, r_valid=0, r_last=0, rf_empty=1, rf_full=0. In-flight data is discarded.

## Timing
- Write at edge t → rf_empty low after edge t → earliest read accepted at edge t+1 → r_data/r_valid visible after t+1.
- One nibble per cycle at full rate; a word drains in 5 consecutive cycles.
- A full word stream at 1 write per 5 cycles with continuous r_en never stalls.
- r_valid/r_last are single-cycle pulses per accepted read; r_data changes only on accepted reads (see Configuration).

## Configuration
- UNTRANSRF_ZERO_IDLE_EN defined: r_data driven to 0 in every cycle following a non-accepted read (r_valid=0).
- Not defined: r_data holds the last read nibble until the next accepted read. r_valid behaviour is identical in both cases.

## Structure
- Shared package untransrf_pkg: BITS, ROWS, GROUPS, WORD_W (=BITS*ROWS), group-index and row-index typedefs, count width constant.
- One sub-module: rf_ptr_wrap, a modulo-N pointer with enable and wrap pulse, instantiated for w_group, r_group and r_addr.

## Test plan
- Reset, write 0x12345 once, r_en held high → r_data 1,2,3,4,5 on consecutive cycles, r_last only with 5, rf_empty high after the fifth read.
- Write 0xAAAAA, 0xBBBBB, 0xCCCCC back-to-back → rf_full=1; fourth write 0xDDDDD ignored; drain yields A×5, B×5, C×5.
- Full, then write 0xEEEEE in the same cycle as the fifth read of group 0 → write rejected, count drops to 2, rf_full=0.
- Read when empty with r_en=1 → r_valid=0, r_data 0 with UNTRANSRF_ZERO_IDLE_EN, else held value.
- Write 0x13579, read 2 nibbles, assert rst_n low → all outputs 0, rf_empty=1; new write 0x2468A drains as 2,4,6,8,A from group 0.
- Random writes/reads over 1000 cycles versus a nibble-queue model → all nibbles returned in order, none lost or duplicated.

Source files
------------

// File: rtl/untransrf_pkg.sv
// Shared sizing and index types for the untransrf parallel-to-serial register file.
package untransrf_pkg;

  localparam int unsigned BITS   = 4;
  localparam int unsigned ROWS   = 5;
  localparam int unsigned GROUPS = 3;
  localparam int unsigned WORD_W = BITS * ROWS;

  localparam int unsigned GRP_W = $clog2(GROUPS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(GROUPS + 1);

  typedef logic [GRP_W-1:0] grp_idx_t;
  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rf_ptr_wrap.sv
// Modulo-N pointer with enable; wrap pulses in the cycle the pointer steps from N-1 back to 0.
module rf_ptr_wrap #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic         clk_w,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] ptr,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q;

  assign wrap = en && (ptr_q == LAST);
  assign ptr  = ptr_q;

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= wrap ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/untransrf_b4r5g3.sv
// 20-bit-in / 4-bit-out register file: one wide write per group, five nibble reads drain it.
// Define UNTRANSRF_ZERO_IDLE_EN to force r_data to 0 after any cycle without an accepted read.
module untransrf_b4r5g3
  import untransrf_pkg::*;
(
  input  logic              clk_w,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [WORD_W-1:0] w_data,
  input  logic              r_en,
  output logic [BITS-1:0]   r_data,
  output logic              r_valid,
  output logic              r_last,
  output logic              rf_full,
  output logic              rf_empty
);

  logic [BITS-1:0] mem_q [GROUPS][ROWS];

  grp_idx_t w_group;
  grp_idx_t r_group;
  row_idx_t r_addr;
  cnt_t     count_q, count_d;

  logic w_acc, r_acc, r_free;
  logic unused_w_wrap, unused_r_wrap;

  logic [BITS-1:0] r_data_q;
  logic            r_valid_q, r_last_q;

  assign rf_full  = (count_q == cnt_t'(GROUPS));
  assign rf_empty = (count_q == '0);

  // Full blocks writes even when this cycle frees a group: no bypass.
  assign w_acc = w_en && !rf_full;
  assign r_acc = r_en && !rf_empty;

  rf_ptr_wrap #(
    .N (GROUPS),
    .W (GRP_W)
  ) u_w_group (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .en    (w_acc),
    .ptr   (w_group),
    .wrap  (unused_w_wrap)
  );

  rf_ptr_wrap #(
    .N (ROWS),
    .W (ROW_W)
  ) u_r_addr (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .en    (r_acc),
    .ptr   (r_addr),
    .wrap  (r_free)
  );

  rf_ptr_wrap #(
    .N (GROUPS),
    .W (GRP_W)
  ) u_r_group (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .en    (r_free),
    .ptr   (r_group),
    .wrap  (unused_r_wrap)
  );

  always_comb begin
    count_d = count_q;
    unique case ({w_acc, r_free})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Row 0 sits in the top nibble of the word and is read out first.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < GROUPS; g++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[g][r] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_q[w_group][r] <= w_data[WORD_W-1-r*BITS -: BITS];
      end
    end
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      r_valid_q <= r_acc;
      r_last_q  <= r_free;
      if (r_acc) begin
        r_data_q <= mem_q[r_group][r_addr];
      end
`ifdef UNTRANSRF_ZERO_IDLE_EN
      else begin
        r_data_q <= '0;
      end
`endif
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign r_last  = r_last_q;

endmodule

// File: tb/tb_untransrf_b4r5g3.sv
// Scoreboard bench for untransrf_b4r5g3: nibbles queued on accepted writes, popped on r_valid.
module tb_untransrf_b4r5g3;

  logic        clk_w;
  logic        rst_n;
  logic        w_en;
  logic [19:0] w_data;
  logic        r_en;
  logic [3:0]  r_data;
  logic        r_valid;
  logic        r_last;
  logic        rf_full;
  logic        rf_empty;

  untransrf_b4r5g3 dut (
    .clk_w    (clk_w),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .w_data   (w_data),
    .r_en     (r_en),
    .r_data   (r_data),
    .r_valid  (r_valid),
    .r_last   (r_last),
    .rf_full  (rf_full),
    .rf_empty (rf_empty)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Model state: {last, nibble} queue, group occupancy, read row, last returned nibble.
  logic [4:0] sb[$];
  int         m_cnt  = 0;
  int         m_raddr = 0;
  logic [3:0] m_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt   = 0;
    m_raddr = 0;
    m_data  = '0;
  endtask

  task automatic step(input logic we, input logic [19:0] wd, input logic re);
    bit         wa, ra, fr;
    logic [4:0] e;
    w_en   = we;
    w_data = wd;
    r_en   = re;
    wa = we && (m_cnt != 3);
    ra = re && (m_cnt != 0);
    fr = ra && (m_raddr == 4);
    if (wa) begin
      for (int i = 0; i < 5; i++) begin
        sb.push_back({(i == 4), wd[19-4*i -: 4]});
      end
    end
    if (wa && !fr) m_cnt++;
    if (fr && !wa) m_cnt--;
    if (ra) m_raddr = fr ? 0 : m_raddr + 1;
    @(posedge clk_w);
    #1;
    check_val("r_valid", {31'd0, r_valid}, {31'd0, ra});
    if (ra) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        m_data = e[3:0];
        check_val("r_data", {28'd0, r_data}, {28'd0, e[3:0]});
        check_val("r_last", {31'd0, r_last}, {31'd0, e[4]});
      end
    end else begin
`ifdef UNTRANSRF_ZERO_IDLE_EN
      m_data = '0;
`endif
      check_val("r_data_idle", {28'd0, r_data}, {28'd0, m_data});
      check_val("r_last_idle", {31'd0, r_last}, 32'd0);
    end
    check_val("rf_full", {31'd0, rf_full}, {31'd0, (m_cnt == 3)});
    check_val("rf_empty", {31'd0, rf_empty}, {31'd0, (m_cnt == 0)});
  endtask

  initial begin
    rst_n  = 1'b0;
    w_en   = 1'b0;
    w_data = '0;
    r_en   = 1'b0;
    repeat (2) @(posedge clk_w);
    #1;
    rst_n = 1'b1;
    check_val("rst_r_data", {28'd0, r_data}, 32'd0);
    check_val("rst_r_valid", {31'd0, r_valid}, 32'd0);
    check_val("rst_rf_empty", {31'd0, rf_empty}, 32'd1);
    check_val("rst_rf_full", {31'd0, rf_full}, 32'd0);

    // Single word, continuous read.
    step(1'b1, 20'h12345, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Fill, ignored fourth write, drain.
    step(1'b1, 20'hAAAAA, 1'b0);
    step(1'b1, 20'hBBBBB, 1'b0);
    step(1'b1, 20'hCCCCC, 1'b0);
    step(1'b1, 20'hDDDDD, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

    // Full, then write in the same cycle as the freeing read: write rejected.
    step(1'b1, 20'hAAAAA, 1'b0);
    step(1'b1, 20'hBBBBB, 1'b0);
    step(1'b1, 20'hCCCCC, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 20'hEEEEE, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1);

    // Read while empty.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Reset in the middle of a group.
    step(1'b1, 20'h13579, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_r_data", {28'd0, r_data}, 32'd0);
    check_val("mid_rst_r_valid", {31'd0, r_valid}, 32'd0);
    check_val("mid_rst_r_last", {31'd0, r_last}, 32'd0);
    check_val("mid_rst_rf_empty", {31'd0, rf_empty}, 32'd1);
    check_val("mid_rst_rf_full", {31'd0, rf_full}, 32'd0);
    model_reset();
    @(posedge clk_w);
    #1;
    rst_n = 1'b1;
    step(1'b1, 20'h2468A, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Random traffic against the nibble-queue model.
    for (int c = 0; c < 1000; c++) begin
      step(($urandom % 4) == 0, 20'($urandom), ($urandom % 3) != 0);
    end
    for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b1);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
